// File: rtl/multicycle_datapath_if.sv
// Instruction-fetch and data-memory request/ready buses for the multicycle datapath.
// The datapath is the master; memories (or a bench) sit on the slave side.
interface multicycle_datapath_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [15:0]           imem_rdata;
  logic                  imem_ready;

  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic [DATA_WIDTH-1:0] dmem_rdata;
  logic                  dmem_ready;

  modport master (
    output imem_req, imem_addr, input imem_rdata, imem_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata, dmem_ready
  );

  modport slave (
    input imem_req, imem_addr, output imem_rdata, imem_ready,
    input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/multicycle_datapath.sv
// Five-state (FETCH/DECODE/EXEC/MEM/WB) multicycle datapath driven by an external
// control unit; fetch and data accesses use req/ready handshakes on the bus interface.
module multicycle_datapath #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,   // must be at least 14 for the jump target splice
  parameter int NUM_REGS   = 8,
  parameter int RESET_PC   = 0,
  parameter bit R0_ZERO    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       jump,
  input  logic       beq,
  input  logic       bne,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic       alu_src,
  input  logic       reg_dst,
  input  logic       mem_to_reg,
  input  logic       reg_write,
  input  logic [1:0] alu_op,
  output logic [3:0] opcode,
  output logic       instr_done,
  multicycle_datapath_if.master bus
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;

  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);

  typedef logic [DATA_WIDTH-1:0] word_t;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           ir_q, ir_d;
  word_t                 a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic                  done_q, done_d;
  word_t                 regs_q [NUM_REGS];

  logic                  rf_we;
  logic [RW-1:0]         rf_waddr;
  word_t                 rf_wdata;

  // Register read ports (used in DECODE)
  logic [RW-1:0] rs_idx, rt_idx;
  word_t         rs_val, rt_val;
  assign rs_idx = ir_q[9 +: RW];
  assign rt_idx = ir_q[6 +: RW];
  assign rs_val = (R0_ZERO && rs_idx == '0) ? '0 : regs_q[rs_idx];
  assign rt_val = (R0_ZERO && rt_idx == '0) ? '0 : regs_q[rt_idx];

  word_t imm, alu_b, alu_res;
  logic  slt, zero;
  assign imm   = {{(DATA_WIDTH-6){ir_q[5]}}, ir_q[5:0]};
  assign alu_b = alu_src ? imm : b_q;
  assign slt   = $signed(a_q) < $signed(alu_b);

  always_comb begin
    alu_res = a_q + alu_b;
    case (alu_op)
      2'b01: alu_res = a_q - alu_b;
      2'b00: begin
        case (ir_q[14:12])
          3'd0: alu_res = a_q + alu_b;
          3'd1: alu_res = a_q - alu_b;
          3'd2: alu_res = ~a_q;
          3'd3: alu_res = a_q << alu_b;
          3'd4: alu_res = a_q >> alu_b;
          3'd5: alu_res = a_q & alu_b;
          3'd6: alu_res = a_q | alu_b;
          3'd7: alu_res = {{(DATA_WIDTH-1){1'b0}}, slt};
        endcase
      end
      default: alu_res = a_q + alu_b;
    endcase
  end
  assign zero = (alu_res == '0);

  // pc_q already points past the current instruction when EXEC runs
  logic [ADDR_WIDTH-1:0] br_pc, jmp_pc;
  assign br_pc  = pc_q + (imm[ADDR_WIDTH-1:0] << 1);
  assign jmp_pc = {pc_q[ADDR_WIDTH-1:13], ir_q[11:0], 1'b0};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    done_d   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = reg_dst ? ir_q[3 +: RW] : rt_idx;
    rf_wdata = mem_to_reg ? mdr_q : alu_q;
    case (state_q)
      FETCH: begin
        if (bus.imem_ready) begin
          ir_d    = bus.imem_rdata;
          pc_d    = pc_q + ADDR_WIDTH'(2);
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d     = rs_val;
        b_d     = rt_val;
        state_d = EXEC;
      end
      EXEC: begin
        alu_d = alu_res;
        if (jump) begin
          pc_d    = jmp_pc;
          done_d  = 1'b1;
          state_d = FETCH;
        end else if ((beq && zero) || (bne && !zero)) begin
          pc_d    = br_pc;
          done_d  = 1'b1;
          state_d = FETCH;
        end else if (beq || bne) begin
          done_d  = 1'b1;
          state_d = FETCH;
        end else if (mem_read || mem_write) begin
          state_d = MEM;
        end else if (reg_write) begin
          state_d = WB;
        end else begin
          done_d  = 1'b1;
          state_d = FETCH;
        end
      end
      MEM: begin
        if (bus.dmem_ready) begin
          if (mem_write) begin
            done_d  = 1'b1;
            state_d = FETCH;
          end else begin
            mdr_d   = bus.dmem_rdata;
            state_d = WB;
          end
        end
      end
      WB: begin
        rf_we   = 1'b1;
        done_d  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RST_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      done_q  <= done_d;
      if (rf_we && !(R0_ZERO && rf_waddr == '0)) regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Requests are masked during reset so an in-flight access is dropped at once
  logic mem_req;
  assign mem_req        = (state_q == MEM) && !rst;
  assign bus.imem_req   = (state_q == FETCH) && !rst;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = mem_req;
  assign bus.dmem_we    = mem_req && mem_write;
  assign bus.dmem_addr  = alu_q[ADDR_WIDTH-1:0];
  assign bus.dmem_wdata = b_q;
  assign opcode         = ir_q[15:12];
  assign instr_done     = done_q;

endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 Parameter DATA_WIDTH, default 16: register, ALU and data-bus width; legal range 16 to 32.
REQ-002 Parameter ADDR_WIDTH, default 16: PC and memory address width; ADDR_WIDTH SHALL be less than or equal to DATA_WIDTH.
REQ-003 Parameter NUM_REGS, default 8: register count, power of 2, 2 to 8; the register index is the low log2(NUM_REGS) bits of each 3-bit instruction field.
REQ-004 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-005 Parameter R0_ZERO, default 1: when 1, register 0 reads as 0 and writes to it are discarded.
REQ-006 clk  in  1  single clock; every state element updates on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write  in  1 each  decoded control signals from the control unit.
REQ-009 alu_op  in  2  ALU operation class.
REQ-010 opcode  out  4  IR[15:12].
REQ-011 imem_req  out  1 / imem_addr  out  ADDR_WIDTH / imem_rdata  in  16 / imem_ready  in  1  instruction fetch port.
REQ-012 dmem_req  out  1 / dmem_we  out  1 / dmem_addr  out  ADDR_WIDTH / dmem_wdata  out  DATA_WIDTH / dmem_rdata  in  DATA_WIDTH / dmem_ready  in  1  data port.
REQ-013 instr_done  out  1  one-cycle pulse when an instruction retires.

Function
REQ-014 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM and WB.
REQ-015 FETCH: imem_req=1 and imem_addr=PC; on a clk edge with imem_ready=1, IR<=imem_rdata, PC<=PC+2 (mod 2^ADDR_WIDTH), and the state goes to DECODE; otherwise FETCH holds.
REQ-016 DECODE (1 cycle):
- A<=reg[IR[11:9]] and B<=reg[IR[8:6]].
- imm = sign-extended IR[5:0] to DATA_WIDTH.
- The control inputs SHALL be sampled only from DECODE until retirement and are required stable over that interval.
REQ-017 ALU operand b = imm if alu_src=1, else B.
REQ-018 ALU function:
- alu_op=10: add.
- alu_op=01: subtract.
- alu_op=00: selected by opcode[2:0]: 0 add, 1 sub, 2 NOT a, 3 a<<b, 4 a>>b (logical), 5 AND, 6 OR, 7 set-less-than (signed) giving 1 or 0.
- alu_op=11: add.
- All results are truncated to DATA_WIDTH.
REQ-019 zero = (ALU result == 0).
REQ-020 EXEC (1 cycle), ALUout<=result; the following rules apply in priority order:
- jump: PC<={PC[ADDR_WIDTH-1:13], IR[11:0], 0}, retire, go to FETCH.
- beq&zero or bne&!zero: PC<=PC+(imm<<1), truncated to ADDR_WIDTH, retire, go to FETCH.
- beq or bne not taken: retire, go to FETCH.
- mem_read or mem_write: go to MEM.
- reg_write: go to WB.
- otherwise: retire, go to FETCH.
REQ-021 MEM: dmem_req=1, dmem_we=mem_write, dmem_addr=ALUout[ADDR_WIDTH-1:0], dmem_wdata=B.
- On dmem_ready=1: a load latches MDR<=dmem_rdata and goes to WB; a store retires and goes to FETCH.
- Otherwise MEM holds.
REQ-022 WB (1 cycle): reg[reg_dst ? IR[5:3] : IR[8:6]] <= (mem_to_reg ? MDR : ALUout), then retire and go to FETCH.
REQ-023 While req is held low, the corresponding ready SHALL be ignored.
REQ-024 While req is high, the address, write enable and write data SHALL remain constant until ready is sampled.
REQ-025 instr_done SHALL be 1 in exactly the cycle after each retirement edge (the first FETCH cycle of the next instruction) and 0 otherwise.
REQ-026 Minimum latency with zero-wait memory:
- jump or branch: 3 cycles.
- ALU operation or store: 4 cycles.
- load: 5 cycles.
- Each wait cycle adds 1.
REQ-027 A register-file read in DECODE SHALL return the value written by the preceding instruction's WB.

Reset
REQ-028 While rst=1 on a clk edge:
- state<=FETCH and PC<=RESET_PC.
- IR, A, B, ALUout, MDR and all registers <= 0.
- instr_done<=0.
REQ-029 While rst is high, imem_req and dmem_req SHALL be 0.
REQ-030 On the first cycle after rst falls, imem_req=1 and imem_addr=RESET_PC.
REQ-031 Reset in MEM or FETCH SHALL abandon the transaction: req SHALL be 0 from the next cycle, and no register or PC update from a ready arriving in the reset cycle SHALL occur.

Verification
REQ-032 Reset, then always-ready memory, then ADDI-class r1 = r0 + 5 (alu_src=1, alu_op=10, reg_write=1) -> r1=5 after 4 cycles, instr_done pulse, next imem_addr=0x0002.
REQ-033 Store r1=5 at address 0x0010 with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles, dmem_addr=0x0010 and dmem_wdata=5 constant throughout, no register write.
REQ-034 beq with r1==r2 and imm=-2 at PC=0x0008 -> next imem_addr=0x0006.
REQ-035 bne with equal operands at PC=0x0008 -> next imem_addr=0x000A.
REQ-036 jump with IR[11:0]=0x123 at PC=0x0004 -> next imem_addr=0x0246.
REQ-037 Load from 0x0020 (memory returns 0xBEEF) -> r3=0xBEEF after 5 cycles; separately, a write to r0 with R0_ZERO=1 -> r0 still reads 0.
REQ-038 rst asserted during MEM with dmem_ready=1 in the same cycle -> MDR and registers unchanged, dmem_req=0 next cycle, imem_addr=RESET_PC after release.
REQ-039 DATA_WIDTH=32: r1=0x7FFFFFFF plus 1 -> 0x80000000; slt of 0x80000000 against 0 -> 1.
